// File: rtl/activate_diff_pipe_reg.sv
// activate_diff_pipe_reg
//   Elastic stage register between the activation unit and the
//   derivative/cost unit. A chain of `depth` register stages carries a
//   lane bus and a side-band bus with valid/ready flow control. Beats move
//   forward whenever the stage ahead is empty or draining, so gaps collapse
//   even while the consumer stalls.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valids and data)
//   flush      synchronous discard of every in-flight beat
//   in_valid   upstream beat present
//   in_ready   a beat can be accepted this cycle
//   in_data    lane bus, lane i at [data_size*(size-i)-1 -: data_size]
//   in_side    side-band bus
//   out_valid  last stage holds a beat
//   out_ready  downstream accepts
//   out_data   lane bus of the last stage (registered)
//   out_side   side-band of the last stage (registered)
//   occupancy  number of valid stages, registered with the valids
module activate_diff_pipe_reg #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int side_size = 82,
    parameter int depth     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [data_size*size-1:0]      in_data,
    input  logic [side_size-1:0]           in_side,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_size*size-1:0]      out_data,
    output logic [side_size-1:0]           out_side,
    output logic [$clog2(depth+1)-1:0]     occupancy
);

    localparam int data_w = data_size * size;
    localparam int occ_w  = $clog2(depth + 1);

    logic [depth-1:0]     valid_reg;
    logic [depth-1:0]     valid_next;
    logic [depth-1:0]     adv;
    logic [depth-1:0]     load;
    logic [data_w-1:0]    data_reg [depth];
    logic [side_size-1:0] side_reg [depth];
    logic [occ_w-1:0]     occ_reg;
    logic [occ_w-1:0]     occ_next;

    // A stage advances when it holds a beat and the stage ahead is either
    // empty or itself advancing. Walking from the output backwards keeps the
    // whole chain in one block, so out_ready ripples to in_ready in a single
    // cycle and a full chain can accept and drain simultaneously.
    always_comb begin
        adv = '0;
        adv[depth-1] = valid_reg[depth-1] & out_ready;
        for (int k = depth - 2; k >= 0; k--) begin
            adv[k] = valid_reg[k] & (~valid_reg[k+1] | adv[k+1]);
        end
    end

    assign in_ready = ~rst & ~flush & (~valid_reg[0] | adv[0]);

    // Flush wins over every load; data registers are left untouched.
    assign valid_next = flush ? '0 : (load | (valid_reg & ~adv));

    always_comb begin
        occ_next = '0;
        for (int k = 0; k < depth; k++) begin
            occ_next = occ_next + occ_w'(valid_next[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            occ_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            occ_reg   <= occ_next;
        end
    end

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_stage
            logic [data_w-1:0]    stage_data_in;
            logic [side_size-1:0] stage_side_in;

            if (gi == 0) begin : g_head
                // in_ready already includes the flush gate
                assign load[gi]      = in_valid & in_ready;
                assign stage_data_in = in_data;
                assign stage_side_in = in_side;
            end else begin : g_body
                assign load[gi]      = adv[gi-1] & ~flush;
                assign stage_data_in = data_reg[gi-1];
                assign stage_side_in = side_reg[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg[gi] <= '0;
                    side_reg[gi] <= '0;
                end else if (load[gi]) begin
                    data_reg[gi] <= stage_data_in;
                    side_reg[gi] <= stage_side_in;
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[depth-1];
    assign out_data  = data_reg[depth-1];
    assign out_side  = side_reg[depth-1];
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_activate_diff_pipe_reg.sv
// Bench for activate_diff_pipe_reg. Four instances (depth 1..4) share the
// clock and reset; each has its own stimulus and a reference model kept as
// a queue of beats with their current stage positions.
module tb_activate_diff_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3:0]        iv, ordy, fl, ir, ov;
    logic [3:0][47:0]  idat, od;
    logic [3:0][81:0]  isd, osd;
    logic [3:0][2:0]   occ;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [47:0] d;
        logic [81:0] s;
        int          pos;
    } beat_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] l3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return {a, b, c};
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_inst
            localparam int D  = (gi == 0) ? 1 : gi + 1;
            localparam int SZ = (gi == 0) ? 1 : 3;
            localparam int DS = (gi == 0) ? 8 : 16;
            localparam int SS = (gi == 0) ? 1 : 82;
            localparam int DW = SZ * DS;
            localparam int OW = $clog2(D + 1);

            logic [DW-1:0] od_w;
            logic [SS-1:0] os_w;
            logic [OW-1:0] oc_w;

            activate_diff_pipe_reg #(
                .size(SZ), .data_size(DS), .side_size(SS), .depth(D)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .flush     (fl[gi]),
                .in_valid  (iv[gi]),
                .in_ready  (ir[gi]),
                .in_data   (idat[gi][DW-1:0]),
                .in_side   (isd[gi][SS-1:0]),
                .out_valid (ov[gi]),
                .out_ready (ordy[gi]),
                .out_data  (od_w),
                .out_side  (os_w),
                .occupancy (oc_w)
            );

            assign od[gi]  = 48'(od_w);
            assign osd[gi] = 82'(os_w);
            assign occ[gi] = 3'(oc_w);

            // Model: queue of beats in acceptance order, each with its stage.
            // The oldest beat may advance up to the last stage, every younger
            // beat up to one stage behind its predecessor's new position.
            beat_t       q[$];
            logic [47:0] last_d = '0;
            logic [81:0] last_s = '0;

            always begin : model_update
                @(posedge clk or posedge rst);
                if (rst) begin
                    q.delete();
                    last_d = '0;
                    last_s = '0;
                end else if (fl[gi]) begin
                    q.delete();
                end else begin : normal
                    bit    rdy;
                    int    lim;
                    int    np;
                    beat_t b;
                    rdy = !(q.size() == D && !ordy[gi]);
                    if (q.size() > 0 && q[0].pos == D - 1 && ordy[gi])
                        void'(q.pop_front());
                    lim = D - 1;
                    for (int i = 0; i < q.size(); i++) begin
                        np = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
                        if (np == D - 1 && q[i].pos != D - 1) begin
                            last_d = q[i].d;
                            last_s = q[i].s;
                        end
                        q[i].pos = np;
                        lim = np - 1;
                    end
                    if (iv[gi] && rdy) begin
                        b.d = 48'(idat[gi][DW-1:0]);
                        b.s = 82'(isd[gi][SS-1:0]);
                        b.pos = 0;
                        if (D == 1) begin
                            last_d = b.d;
                            last_s = b.s;
                        end
                        q.push_back(b);
                    end
                end
            end

            always begin : model_compare
                logic ev;
                logic er;
                @(negedge clk);
                ev = (q.size() > 0) && (q[0].pos == D - 1);
                er = !rst && !fl[gi] && !(q.size() == D && !ordy[gi]);
                chk($sformatf("d%0d.out_valid", D), 128'(ov[gi]), 128'(ev));
                chk($sformatf("d%0d.occupancy", D), 128'(occ[gi]), 128'(q.size()));
                chk($sformatf("d%0d.out_data", D), 128'(od[gi]), 128'(last_d));
                chk($sformatf("d%0d.out_side", D), 128'(osd[gi]), 128'(last_s));
                chk($sformatf("d%0d.in_ready", D), 128'(ir[gi]), 128'(er));
            end
        end
    endgenerate

    initial begin : stim
        int nxt;
        int acc;
        int dlv;
        int lat;

        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        fl   = '0;
        idat = '0;
        isd  = '0;
        repeat (2) step();
        chk("reset.occupancy", 128'(occ[1]), 128'(0));
        chk("reset.out_valid", 128'(ov), 128'(0));
        chk("reset.in_ready", 128'(ir), 128'(0));
        rst = 1'b0;
        step();

        // depth 2 streaming with out_ready held high
        ordy[1] = 1'b1;
        iv[1]   = 1'b1;
        idat[1] = l3(16'h0100, 16'hFF00, 16'h0080);
        isd[1]  = 82'h11;
        step();
        idat[1] = l3(16'd1, 16'd2, 16'd3);
        isd[1]  = 82'h22;
        chk("s1.occ_c1", 128'(occ[1]), 128'(1));
        step();
        idat[1] = l3(16'd4, 16'd5, 16'd6);
        isd[1]  = 82'h33;
        chk("s1.valid_c2", 128'(ov[1]), 128'(1));
        chk("s1.data_c2", 128'(od[1]), 128'(48'h0100_FF00_0080));
        chk("s1.side_c2", 128'(osd[1]), 128'(82'h11));
        step();
        iv[1] = 1'b0;
        chk("s1.data_c3", 128'(od[1]), 128'(48'h0001_0002_0003));
        chk("s1.occ_c3", 128'(occ[1]), 128'(2));
        step();
        chk("s1.data_c4", 128'(od[1]), 128'(48'h0004_0005_0006));
        chk("s1.side_c4", 128'(osd[1]), 128'(82'h33));
        step();
        chk("s1.empty_valid", 128'(ov[1]), 128'(0));
        chk("s1.empty_hold", 128'(od[1]), 128'(48'h0004_0005_0006));
        ordy[1] = 1'b0;

        // depth 3 bubble collapse with stalled consumer
        iv[2]   = 1'b1;
        idat[2] = l3(16'hA, 16'hA, 16'hA);
        isd[2]  = 82'hA;
        step();
        idat[2] = l3(16'hB, 16'hB, 16'hB);
        isd[2]  = 82'hB;
        step();
        iv[2] = 1'b0;
        step();
        step();
        chk("s2.occ_two", 128'(occ[2]), 128'(2));
        chk("s2.ready_two", 128'(ir[2]), 128'(1));
        chk("s2.head_a", 128'(od[2]), 128'(48'h000A_000A_000A));
        iv[2]   = 1'b1;
        idat[2] = l3(16'hC, 16'hC, 16'hC);
        isd[2]  = 82'hC;
        step();
        idat[2] = l3(16'hD, 16'hD, 16'hD);
        isd[2]  = 82'hD;
        chk("s2.occ_full", 128'(occ[2]), 128'(3));
        chk("s2.ready_full", 128'(ir[2]), 128'(0));
        ordy[2] = 1'b1;
        #1;
        chk("s2.ready_drain", 128'(ir[2]), 128'(1));
        step();
        ordy[2] = 1'b0;
        iv[2]   = 1'b0;
        #1;
        chk("s2.occ_after", 128'(occ[2]), 128'(3));
        chk("s2.head_b", 128'(od[2]), 128'(48'h000B_000B_000B));
        chk("s2.ready_after", 128'(ir[2]), 128'(0));
        ordy[2] = 1'b1;
        repeat (4) step();
        ordy[2] = 1'b0;

        // depth 4 full, out_ready toggling
        nxt = 1;
        iv[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idat[3] = 48'(nxt);
            isd[3]  = 82'(nxt);
            #1;
            if (ir[3]) nxt++;
            step();
        end
        chk("s3.occ_full", 128'(occ[3]), 128'(4));
        acc = 0;
        dlv = 0;
        for (int i = 0; i < 8; i++) begin
            ordy[3] = (i % 2 == 0);
            idat[3] = 48'(nxt);
            isd[3]  = 82'(nxt);
            #1;
            if (ir[3]) begin
                acc++;
                nxt++;
            end
            if (ov[3] && ordy[3]) dlv++;
            step();
        end
        chk("s3.accepted", 128'(acc), 128'(4));
        chk("s3.delivered", 128'(dlv), 128'(4));
        iv[3]   = 1'b0;
        ordy[3] = 1'b1;
        repeat (5) step();
        ordy[3] = 1'b0;
        chk("s3.drained", 128'(occ[3]), 128'(0));

        // depth 2 flush
        iv[1]   = 1'b1;
        idat[1] = l3(16'h1111, 16'h2222, 16'h3333);
        isd[1]  = 82'h1;
        step();
        idat[1] = l3(16'h4444, 16'h5555, 16'h6666);
        isd[1]  = 82'h2;
        step();
        chk("s4.occ_pre", 128'(occ[1]), 128'(2));
        fl[1]   = 1'b1;
        idat[1] = l3(16'h7777, 16'h7777, 16'h7777);
        #1;
        chk("s4.ready_flush", 128'(ir[1]), 128'(0));
        step();
        fl[1] = 1'b0;
        iv[1] = 1'b0;
        chk("s4.occ_post", 128'(occ[1]), 128'(0));
        chk("s4.valid_post", 128'(ov[1]), 128'(0));
        chk("s4.data_kept", 128'(od[1]), 128'(48'h1111_2222_3333));
        iv[1]   = 1'b1;
        idat[1] = l3(16'h0ABC, 16'h0DEF, 16'h0123);
        step();
        iv[1] = 1'b0;
        chk("s4.next_c1", 128'(ov[1]), 128'(0));
        step();
        chk("s4.next_c2", 128'(ov[1]), 128'(1));
        chk("s4.next_data", 128'(od[1]), 128'(48'h0ABC_0DEF_0123));
        ordy[1] = 1'b1;
        step();
        ordy[1] = 1'b0;

        // depth 2 asynchronous reset mid-cycle
        iv[1]   = 1'b1;
        idat[1] = l3(16'h0F0F, 16'h0F0F, 16'h0F0F);
        isd[1]  = 82'h3;
        step();
        idat[1] = l3(16'h0E0E, 16'h0E0E, 16'h0E0E);
        step();
        iv[1] = 1'b0;
        chk("s5.occ_pre", 128'(occ[1]), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("s5.valid_async", 128'(ov[1]), 128'(0));
        chk("s5.data_async", 128'(od[1]), 128'(0));
        chk("s5.side_async", 128'(osd[1]), 128'(0));
        chk("s5.occ_async", 128'(occ[1]), 128'(0));
        chk("s5.ready_async", 128'(ir[1]), 128'(0));
        #2;
        rst     = 1'b0;
        iv[1]   = 1'b1;
        ordy[1] = 1'b1;
        idat[1] = l3(16'h0055, 16'h0066, 16'h0077);
        step();
        iv[1] = 1'b0;
        lat = 1;
        while (!ov[1] && lat < 8) begin
            step();
            lat++;
        end
        chk("s5.latency", 128'(lat), 128'(2));
        chk("s5.data", 128'(od[1]), 128'(48'h0055_0066_0077));
        ordy[1] = 1'b0;
        step();

        // depth 1, narrow lanes, random handshakes
        for (int i = 0; i < 1000; i++) begin
            iv[0]   = 1'($urandom_range(0, 1));
            ordy[0] = 1'($urandom_range(0, 1));
            idat[0] = 48'($urandom_range(0, 255));
            isd[0]  = 82'($urandom_range(0, 1));
            #1;
            chk("s6.ready_rule", 128'(ir[0]), 128'(!ov[0] || ordy[0]));
            step();
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/activate_diff_pipe_reg.md
Name: activate_diff_pipe_reg

Overview:
- Parametrised elastic successor to the fixed one-cycle activation-derivative stage register in the backprop pipeline.
- Carries a vector lane bus (predict/w/x/y/z-style data packed as size lanes of data_size bits) plus one packed side-band bus (act/cost/dense type, backprop control).
- The path is a configurable-depth chain of stages with per-stage valid, valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between the activation unit and the derivative/cost unit so downstream stalls no longer corrupt in-flight data.

Parameters:
- size, 3, number of data lanes per beat.
- data_size, 16, bits per lane (signed Q8.8 by convention; the block treats it as opaque).
- side_size, 82, packed side-band width (act 4 + cost 8 + dense 4 + backprop control 66).
- depth, 2, number of register stages (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all in-flight beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  data_size*size  lane bus; lane i is bits [data_size*(size-i)-1 -: data_size].
- in_side  input  side_size  side-band bus.
- out_valid  output  1  valid flag of the last stage.
- out_ready  input  1  downstream accepts.
- out_data  output  data_size*size  data of the last stage.
- out_side  output  side_size  side-band of the last stage.
- occupancy  output  $clog2(depth+1)  count of valid stages.

Behaviour:
- Stage state: valid[k], data[k], side[k] for k = 0..depth-1. Stage depth-1 drives the out_* ports directly from registers; there is no combinational path from in_data to out_data.
- Reset (async, rst=1): all valid=0, all data/side=0. Consequently out_valid=0, out_data=0, out_side=0, occupancy=0.
- in_ready is 0 while rst is asserted.
- Advance terms (combinational):
  - adv[depth-1] = valid[depth-1] & out_ready.
  - adv[k] = valid[k] & (!valid[k+1] | adv[k+1]).
- Ready: in_ready = !flush & (!valid[0] | adv[0]). The ready chain is combinational from out_ready to in_ready; this is intentional.
- Load:
  - Stage 0 loads in_data/in_side when in_valid & in_ready.
  - Stage k>0 loads data[k-1]/side[k-1] when adv[k-1].
  - Data/side registers change only on load; otherwise they hold.
- Valid update: valid[k] <= load[k] | (valid[k] & !adv[k]).
- Bubble collapsing: a beat moves forward whenever the next stage is empty or draining, even while out_ready=0. Gaps compress until the chain is full.
- Latency: an accepted beat reaches out_valid exactly depth cycles later, provided out_ready was held 1.
- Throughput: one beat per cycle when out_ready is held 1.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- Full: all valid=1 and out_ready=0 gives in_ready=0. If out_ready rises, in_ready rises the same cycle, so a simultaneous accept and drain keep the chain full.
- Empty: out_valid=0; out_data/out_side hold the last delivered beat (not cleared).
- Flush:
  - Takes priority over all loads. On the next edge every valid=0 and no input is accepted (in_ready=0 during flush).
  - A beat presented by the last stage in the flush cycle counts as delivered if out_ready=1.
  - Data registers are not cleared.
- occupancy = popcount(valid), registered with the valids; range 0..depth.
- Mid-operation reset: immediate async clear as in the reset bullet; the first accept is possible on the first edge after rst deasserts.

Test Plan:
- depth=2, out_ready=1; lane beats {0x0100,0xFF00,0x0080}, {1,2,3}, {4,5,6} on consecutive cycles -> out_valid on cycles 2,3,4 with identical data/side in order; occupancy steady at 2.
- depth=3; push beats A and B with out_ready=0 -> both collapse to stages 2 and 1, occupancy=2, in_ready=1. Push C -> occupancy=3, in_ready=0. Raise out_ready for one cycle -> A delivered, D accepted that same cycle.
- depth=4, full, toggle out_ready 1/0 every cycle for 8 cycles with in_valid=1 -> exactly 4 beats accepted and 4 delivered, order preserved, no duplicates.
- depth=2, two beats in flight; assert flush with in_valid=1 and out_ready=0 -> next cycle occupancy=0, out_valid=0, flush-cycle input not accepted. Next beat then appears after 2 cycles.
- Assert rst asynchronously (between edges) with occupancy=2 -> out_valid, out_data, out_side and occupancy go to 0 without a clock edge. After deassert, first beat latency = depth.
- depth=1, size=1, data_size=8, side_size=1; random valid/ready for 1000 cycles -> scoreboard match; in_ready == (!out_valid | out_ready) every cycle.
